// File: rtl/sico_stream_pkg.sv
// Shared types and SiCo channel entry points for the stream player.
// The SiCo* routines model the host end of a channel so the player can run stand-alone.
package sico_stream_pkg;

  typedef enum logic [1:0] {INIT, RUN, DRAIN, DONE} state_e;

  function automatic int dpi_width(input int width);
    if (width <= 32) return 32;
    if (width <= 128) return 128;
    return 1024;
  endfunction

  localparam int HOST_MAX = 64;

  // Host-side channel state: one shared word list, rewound by Reset.
  logic [1023:0] host_data [HOST_MAX];
  bit            host_last [HOST_MAX];
  int            host_len;
  int            host_pos;
  bit            host_stall;
  string         host_channel;
  int            host_width;
  longint        host_now;
  int            host_log;
  int            n_init;
  int            n_reset;
  int            n_get;
  int            n_get32;
  int            n_get128;
  int            n_get1024;

  function automatic void host_init(input string channel, input int width);
    host_channel = channel;
    host_width   = width;
    n_init       = n_init + 1;
    host_log     = host_log * 10 + 2;
  endfunction

  function automatic void host_reset(input string channel);
    host_channel = channel;
    host_pos     = 0;
    n_reset      = n_reset + 1;
    host_log     = host_log * 10 + 1;
  endfunction

  function automatic void host_fetch(input string channel, input longint now,
                                     output logic [1023:0] data, output bit avail,
                                     output bit last);
    host_channel = channel;
    host_now     = now;
    n_get        = n_get + 1;
    if (!host_stall && host_pos < host_len && host_pos < HOST_MAX) begin
      data     = host_data[host_pos];
      last     = host_last[host_pos];
      avail    = 1'b1;
      host_pos = host_pos + 1;
    end else begin
      data  = '0;
      last  = 1'b0;
      avail = 1'b0;
    end
  endfunction

  function automatic void SiCoDpiStreamInit32(input string channel, input int width);
    host_init(channel, width);
  endfunction

  function automatic void SiCoDpiStreamInit128(input string channel, input int width);
    host_init(channel, width);
  endfunction

  function automatic void SiCoDpiStreamInit1024(input string channel, input int width);
    host_init(channel, width);
  endfunction

  function automatic void SiCoDpiStreamReset32(input string channel);
    host_reset(channel);
  endfunction

  function automatic void SiCoDpiStreamReset128(input string channel);
    host_reset(channel);
  endfunction

  function automatic void SiCoDpiStreamReset1024(input string channel);
    host_reset(channel);
  endfunction

  function automatic void SiCoDpiStreamGet32(input string channel, input longint now,
                                             output logic [31:0] data, output bit avail,
                                             output bit last);
    logic [1023:0] raw;
    host_fetch(channel, now, raw, avail, last);
    data    = raw[31:0];
    n_get32 = n_get32 + 1;
  endfunction

  function automatic void SiCoDpiStreamGet128(input string channel, input longint now,
                                              output logic [127:0] data, output bit avail,
                                              output bit last);
    logic [1023:0] raw;
    host_fetch(channel, now, raw, avail, last);
    data     = raw[127:0];
    n_get128 = n_get128 + 1;
  endfunction

  function automatic void SiCoDpiStreamGet1024(input string channel, input longint now,
                                               output logic [1023:0] data, output bit avail,
                                               output bit last);
    host_fetch(channel, now, data, avail, last);
    n_get1024 = n_get1024 + 1;
  endfunction

  // Width-class dispatch so the player carries a single call site per operation.
  function automatic void sico_init(input int dw, input string channel, input int width);
    case (dw)
      32:      SiCoDpiStreamInit32(channel, width);
      128:     SiCoDpiStreamInit128(channel, width);
      default: SiCoDpiStreamInit1024(channel, width);
    endcase
  endfunction

  function automatic void sico_reset(input int dw, input string channel);
    case (dw)
      32:      SiCoDpiStreamReset32(channel);
      128:     SiCoDpiStreamReset128(channel);
      default: SiCoDpiStreamReset1024(channel);
    endcase
  endfunction

  function automatic void sico_get(input int dw, input string channel, input longint now,
                                   output logic [1023:0] data, output bit avail,
                                   output bit last);
    logic [31:0]  d32;
    logic [127:0] d128;
    data = '0;
    case (dw)
      32: begin
        SiCoDpiStreamGet32(channel, now, d32, avail, last);
        data[31:0] = d32;
      end
      128: begin
        SiCoDpiStreamGet128(channel, now, d128, avail, last);
        data[127:0] = d128;
      end
      default: SiCoDpiStreamGet1024(channel, now, data, avail, last);
    endcase
  endfunction

endpackage

// File: rtl/sico_stream_fifo.sv
// First-word-fall-through FIFO holding {last, data} entries; reset flushes it.
module sico_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH:0]         data_i,
  input  logic                   pop_i,
  output logic [WIDTH:0]         head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sico_stream_player.sv
// Pulls words from a SiCo channel into a prefetch FIFO and presents them as a
// valid/ready stream with end-of-stream and starvation tracking.
module sico_stream_player
  import sico_stream_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter string            CHANNEL = "stream",
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   eos_o,
  output logic [CNT_W-1:0]       underrun_o
);

  localparam int DW = dpi_width(WIDTH);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  state_e           state_q;
  entry_t           land_q;
  logic             land_vld_q;
  logic [CNT_W-1:0] under_q;

  entry_t           fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LW-1:0]    fifo_level;
  logic             fifo_push;
  logic             fifo_pop;
  entry_t           head;
  logic [LW-1:0]    level;
  logic             valid;
  logic             pop;

  logic [1023:0]    fetch_data;
  bit               fetch_avail;
  bit               fetch_last;

  // A fetched word lands in land_q on the fetch edge; the FIFO absorbs it on
  // the next edge, and when the FIFO is empty land_q is the head directly.
  assign level     = fifo_level + LW'(land_vld_q);
  assign valid     = (level != '0);
  assign head      = fifo_empty ? land_q : fifo_head;
  assign pop       = valid && ready_i;
  assign fifo_pop  = pop && !fifo_empty;
  assign fifo_push = land_vld_q && !(pop && fifo_empty) && !fifo_full;

  sico_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (land_q),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      land_q     <= '0;
      land_vld_q <= 1'b0;
      under_q    <= '0;
    end else begin
      land_vld_q <= 1'b0;
      case (state_q)
        INIT: begin
          sico_reset(DW, CHANNEL);
          sico_init(DW, CHANNEL, WIDTH);
          state_q <= RUN;
        end
        RUN: begin
          if (ready_i && !valid && under_q != '1) under_q <= under_q + 1'b1;
          if (level < LW'(DEPTH)) begin
            sico_get(DW, CHANNEL, longint'($time), fetch_data, fetch_avail, fetch_last);
            land_vld_q <= fetch_avail;
            land_q     <= {fetch_last, fetch_data[WIDTH-1:0]};
            if (fetch_avail && fetch_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (level == '0 || (level == LW'(1) && pop)) state_q <= DONE;
        end
        default: state_q <= DONE;
      endcase
    end
  end

  assign data_o     = valid ? head.data : RST_VAL;
  assign valid_o    = valid;
  assign last_o     = valid && head.last;
  assign level_o    = level;
  assign eos_o      = (state_q == DONE);
  assign underrun_o = under_q;

endmodule

// File: tb/tb_sico_stream_player.sv
// Directed bench for sico_stream_player: four instances, released one at a time,
// all fed from the shared host-side channel model.
module tb_sico_stream_player;
  import sico_stream_pkg::*;

  localparam logic [199:0] PA = {25{8'hA5}};
  localparam logic [199:0] PB = {25{8'h5A}};

  logic clk;
  int   checks;
  int   failures;

  logic rst_a, ready_a, valid_a, last_a, eos_a;
  logic [7:0]  data_a;
  logic [2:0]  level_a;
  logic [15:0] under_a;

  logic rst_b, ready_b, valid_b, last_b, eos_b;
  logic [7:0]  data_b;
  logic [2:0]  level_b;
  logic [3:0]  under_b;

  logic rst_c, ready_c, valid_c, last_c, eos_c;
  logic [0:0]  data_c;
  logic [2:0]  level_c;
  logic [15:0] under_c;

  logic rst_d, ready_d, valid_d, last_d, eos_d;
  logic [199:0] data_d;
  logic [1:0]   level_d;
  logic [15:0]  under_d;

  logic [1023:0] w;

  sico_stream_player #(.WIDTH(8), .DEPTH(4), .CHANNEL("stream"), .RST_VAL(8'hEE), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_ni(rst_a), .data_o(data_a), .valid_o(valid_a), .ready_i(ready_a),
    .last_o(last_a), .level_o(level_a), .eos_o(eos_a), .underrun_o(under_a));

  sico_stream_player #(.WIDTH(8), .DEPTH(4), .CHANNEL("sat"), .RST_VAL(8'h00), .CNT_W(4)) u_b (
    .clk_i(clk), .rst_ni(rst_b), .data_o(data_b), .valid_o(valid_b), .ready_i(ready_b),
    .last_o(last_b), .level_o(level_b), .eos_o(eos_b), .underrun_o(under_b));

  sico_stream_player #(.WIDTH(1), .DEPTH(4), .CHANNEL("bit"), .RST_VAL(1'b0), .CNT_W(16)) u_c (
    .clk_i(clk), .rst_ni(rst_c), .data_o(data_c), .valid_o(valid_c), .ready_i(ready_c),
    .last_o(last_c), .level_o(level_c), .eos_o(eos_c), .underrun_o(under_c));

  sico_stream_player #(.WIDTH(200), .DEPTH(2), .CHANNEL("wide"), .RST_VAL('0), .CNT_W(16)) u_d (
    .clk_i(clk), .rst_ni(rst_d), .data_o(data_d), .valid_o(valid_d), .ready_i(ready_d),
    .last_o(last_d), .level_o(level_d), .eos_o(eos_d), .underrun_o(under_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_clear();
    host_len   = 0;
    host_pos   = 0;
    host_stall = 1'b0;
    host_log   = 0;
    n_get      = 0;
    n_get32    = 0;
    n_get1024  = 0;
  endtask

  task automatic host_put(input logic [1023:0] d, input bit l);
    host_data[host_len] = d;
    host_last[host_len] = l;
    host_len = host_len + 1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0; ready_d = 1'b0;
    host_clear();
    #3;

    // Reset values
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 8'hEE);
    check("rst_level", level_a, 0);
    check("rst_last", last_a, 0);
    check("rst_eos", eos_a, 0);
    check("rst_under", under_a, 0);

    // Basic flow: 0x11, 0x22, 0x33(last)
    host_put(1024'h11, 1'b0);
    host_put(1024'h22, 1'b0);
    host_put(1024'h33, 1'b1);
    tick();
    rst_a = 1'b1;
    tick();
    check("init_order", host_log, 12);
    check("init_chan", (host_channel == "stream"), 1);
    check("init_width", host_width, 8);
    check("init_novalid", valid_a, 0);
    tick();
    check("ff_valid", valid_a, 1);
    check("ff_data", data_a, 8'h11);
    check("ff_level", level_a, 1);
    ready_a = 1'b1;
    tick();
    check("flow_d1", data_a, 8'h22);
    check("flow_l1", last_a, 0);
    tick();
    check("flow_d2", data_a, 8'h33);
    check("flow_last", last_a, 1);
    tick();
    check("flow_eos", eos_a, 1);
    check("flow_valid_end", valid_a, 0);
    check("flow_data_end", data_a, 8'hEE);
    check("flow_under", under_a, 0);
    check("flow_gets", n_get, 3);
    tick();
    tick();
    check("done_sticky", eos_a, 1);
    check("done_nofetch", n_get, 3);

    // Backpressure: 8 words, consumer stalled for 10 cycles
    rst_a = 1'b0;
    ready_a = 1'b0;
    host_clear();
    for (int i = 0; i < 8; i++) host_put(1024'(i), (i == 7));
    tick();
    rst_a = 1'b1;
    tick();
    repeat (10) tick();
    check("bp_level", level_a, 4);
    check("bp_gets", n_get, 4);
    check("bp_head", data_a, 8'h00);
    ready_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp_data", data_a, 1024'(i));
      check("bp_last", last_a, (i == 7));
      tick();
    end
    check("bp_eos", eos_a, 1);
    check("bp_gets_all", n_get, 8);
    check("bp_under", under_a, 0);

    // Reset with 3 words buffered, then restart from word 0
    rst_a = 1'b0;
    ready_a = 1'b0;
    host_clear();
    for (int i = 0; i < 8; i++) host_put(1024'(8'h40 + i), (i == 7));
    tick();
    rst_a = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("mid_level", level_a, 3);
    #2;
    rst_a = 1'b0;
    #1;
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_level", level_a, 0);
    check("mid_rst_data", data_a, 8'hEE);
    check("mid_rst_last", last_a, 0);
    host_log = 0;
    tick();
    rst_a = 1'b1;
    tick();
    check("mid_order", host_log, 12);
    check("mid_rewind", host_pos, 0);
    tick();
    check("mid_restart_data", data_a, 8'h40);
    check("mid_restart_level", level_a, 1);

    // Starvation with the host stalled and the consumer ready
    rst_a = 1'b0;
    host_clear();
    host_put(1024'h5C, 1'b0);
    host_stall = 1'b1;
    ready_a = 1'b1;
    tick();
    rst_a = 1'b1;
    tick();
    check("starve_init", under_a, 0);
    repeat (5) tick();
    check("starve_cnt", under_a, 5);
    check("starve_valid", valid_a, 0);
    check("starve_data", data_a, 8'hEE);
    ready_a = 1'b0;
    tick();
    tick();
    check("starve_hold", under_a, 5);
    host_stall = 1'b0;
    tick();
    check("starve_recover", data_a, 8'h5C);
    check("starve_hold2", under_a, 5);

    // Saturation of a 4-bit underrun counter
    rst_a = 1'b0;
    host_clear();
    ready_b = 1'b1;
    tick();
    rst_b = 1'b1;
    tick();
    repeat (14) tick();
    check("sat_14", under_b, 14);
    repeat (6) tick();
    check("sat_15", under_b, 15);
    check("sat_valid", valid_b, 0);

    // WIDTH=1 uses the 32-bit class
    rst_b = 1'b0;
    ready_b = 1'b0;
    host_clear();
    host_put(1024'h1, 1'b0);
    host_put(1024'h0, 1'b0);
    host_put(1024'h1, 1'b1);
    tick();
    rst_c = 1'b1;
    tick();
    tick();
    check("w1_d0", data_c, 1);
    check("w1_v0", valid_c, 1);
    ready_c = 1'b1;
    tick();
    check("w1_d1", data_c, 0);
    check("w1_v1", valid_c, 1);
    tick();
    check("w1_d2", data_c, 1);
    check("w1_last", last_c, 1);
    tick();
    check("w1_eos", eos_c, 1);
    check("w1_get32", n_get32, 3);
    check("w1_get1024", n_get1024, 0);

    // WIDTH=200 uses the 1024-bit class; bits above 200 carry junk
    rst_c = 1'b0;
    ready_c = 1'b0;
    host_clear();
    w = '1;
    w[199:0] = PA;
    host_put(w, 1'b0);
    w[199:0] = PB;
    host_put(w, 1'b0);
    w[199:0] = PA;
    host_put(w, 1'b1);
    tick();
    rst_d = 1'b1;
    tick();
    check("w200_width", host_width, 200);
    tick();
    check("w200_d0", data_d, PA);
    ready_d = 1'b1;
    tick();
    check("w200_d1", data_d, PB);
    tick();
    check("w200_d2", data_d, PA);
    check("w200_last", last_d, 1);
    tick();
    check("w200_eos", eos_d, 1);
    check("w200_get1024", n_get1024, 3);
    check("w200_get32", n_get32, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sico_stream_player.md
# sico_stream_player

Clocked, flow-controlled successor to the free-running SiCo player. It pulls words from a named SiCo DPI channel into a local prefetch FIFO and presents them as a valid/ready stream. It also tracks end-of-stream and underrun. It sits at the testbench edge, driving DUT input streams from host-side co-simulation.

## Interface
- `WIDTH`, 8: data width in bits, 1..1024.
- `DEPTH`, 4: prefetch FIFO entries, power of two, 2..64.
- `CHANNEL`, "stream": SiCo channel name.
- `RST_VAL`, {WIDTH{1'b0}}: value of `data_o` while no word is held.
- `CNT_W`, 16: width of the underrun counter.
- `clk_i`  in  1  sole clock; all DPI calls happen on its rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `data_o`  out  WIDTH  head-of-FIFO word.
- `valid_o`  out  1  `data_o` holds a stream word.
- `ready_i`  in  1  consumer accepts the word this cycle.
- `last_o`  out  1  the head word is the final word of the stream.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `eos_o`  out  1  the stream is finished and fully consumed.
- `underrun_o`  out  CNT_W  count of starved cycles; saturates at all-ones.

## Operation
- DPI width class: DW = 32, 128 or 1024, the smallest class that is ≥ WIDTH. Calls are `SiCoDpiStreamInit<DW>(CHANNEL, WIDTH)`, `SiCoDpiStreamGet<DW>(CHANNEL, now, data, avail, last)` and `SiCoDpiStreamReset<DW>(CHANNEL)`.
- Only `data[WIDTH-1:0]` is used; the upper bits are ignored.
- FSM states:
  - INIT: one cycle after reset release; calls Init, then goes to RUN.
  - RUN: fetch on each edge where the pre-edge `level_o < DEPTH`.
    - `avail=1`: push the word with its `last` flag.
    - A pushed word with `last=1` moves the FSM to DRAIN.
    - `avail=0`: no push.
  - DRAIN: no further fetches; goes to DONE when the FIFO empties.
  - DONE: terminal; `eos_o=1`. Only reset leaves it.
- Fetch eligibility uses pre-edge occupancy only. A full FIFO popped on the same edge does not fetch that edge.
- Handshake:
  - Pop on edge when `valid_o && ready_i`.
  - `valid_o` is never withdrawn without a pop.
  - `data_o` and `last_o` stay stable while `valid_o=1` and `ready_i=0`.
- Simultaneous push and pop: level unchanged; order preserved. When the FIFO holds exactly one entry, the pushed word becomes head after the pop.
- Underrun: increment on each edge in RUN where `ready_i=1` and `valid_o=0`. There is no increment in INIT, DRAIN or DONE.
- Reset assertion at any time:
  - FIFO is flushed; every prefetched word is discarded.
  - Counter cleared; FSM forced to INIT.
  - `SiCoDpiStreamReset` is called on the first edge after release, before Init. The host side rewinds.
- Reset values: `data_o=RST_VAL`, `valid_o=0`, `last_o=0`, `level_o=0`, `eos_o=0`, `underrun_o=0`.
- `data_o` shows `RST_VAL` whenever `valid_o=0`.

## Timing
- Latency from DPI fetch to output:
  - A word fetched at edge N into an empty FIFO drives `valid_o=1` after edge N.
  - It can be popped at edge N+1 (first-word fall-through).
- Throughput: sustained 1 word/cycle with `ready_i` held high and the host always having data, for any DEPTH ≥ 2.
- INIT: the first fetch happens at the second edge after reset release.
- `eos_o` rises after the edge that pops the `last` word.
- The `level_o` update is registered and visible after the edge.
- `now` passed to Get is the current simulation time in the codebase's SimTime units.

## Structure
- Package `sico_stream_pkg`:
  - `dpi_width(WIDTH)` function.
  - `state_e` enum {INIT, RUN, DRAIN, DONE}.
  - Packed entry typedef {last, data} parameterised via a localparam in the user.
- Sub-module `sico_stream_fifo`: synchronous FWFT FIFO of WIDTH+1 bits, parameters DEPTH and WIDTH. It has push/pop/full/empty/level and async active-low flush, all on `clk_i`/`rst_ni`.
- The DPI calls and the FSM live in the top module only.

## Test plan
- Basic flow: host supplies 0x11, 0x22, 0x33 (last on 0x33) with `ready_i=1` → outputs 0x11/0x22/0x33 on consecutive cycles; `last_o` with 0x33; `eos_o=1` the cycle after; `underrun_o=0`.
- Backpressure: DEPTH=4, `ready_i=0` for 10 cycles, host has 8 words → `level_o` saturates at 4, exactly 4 Get calls; release `ready_i` → words 0..7 arrive in order with no gaps.
- Starvation: host `avail=0` for 5 RUN cycles with `ready_i=1` → `underrun_o=5`, `valid_o=0`, `data_o=RST_VAL`.
- Saturation: CNT_W=4, 20 starved cycles → `underrun_o=15`.
- Reset mid-stream: assert `rst_ni` with 3 words buffered → all outputs at reset values immediately (async); after release, Reset is called, then Init, and the stream restarts from word 0.
- Wide/narrow: WIDTH=1 and WIDTH=200 with pattern 0x1,0x0,0x1 / alternating 0xA5…A5 → correct bits, using the 32/1024 DPI variants respectively.
